// File: rtl/instr_stream_encoder.sv
// Packs symbolic instruction requests into RV32I words and writes them to
// consecutive instruction-memory addresses, one word per two cycles.
module instr_stream_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_class,
    input  logic [2:0]               req_funct3,
    input  logic                     req_funct7b5,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    input  logic [31:0]              req_imm,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                full_q, full_d;
    logic                clr_pend_q, clr_pend_d;

    logic [31:0]         enc_word;
    logic [1:0]          chk_code;
    logic signed [31:0]  imm_s;
    logic                clr_eff;
    logic                imm12_bad;

    assign imm_s     = req_imm;
    assign imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);

    // A clear seen during WRITE is remembered and applied once the write retires.
    assign clr_eff   = clear || clr_pend_q;

    assign req_ready = (state_q == IDLE) && !clr_eff && !reset;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign full      = full_q;
    assign count     = count_q;

    // Field packing and immediate legality per instruction class.
    always_comb begin
        enc_word = '0;
        chk_code = 2'd0;
        unique case (req_class)
            3'd0: enc_word = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1,
                              req_funct3, req_rd, OP_R};
            3'd1: begin
                enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
                if (imm12_bad) chk_code = 2'd1;
            end
            3'd2: begin
                enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LW};
                if (imm12_bad) chk_code = 2'd1;
            end
            3'd3: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010,
                            req_imm[4:0], OP_SW};
                if (imm12_bad) chk_code = 2'd1;
            end
            3'd4: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], OP_BR};
                if ((imm_s < -32'sd4096) || (imm_s > 32'sd4094)) chk_code = 2'd1;
                else if (req_imm[0])                              chk_code = 2'd2;
            end
            3'd5: begin
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OP_JAL};
                if ((imm_s < -32'sd1048576) || (imm_s > 32'sd1048574)) chk_code = 2'd1;
                else if (req_imm[0])                                    chk_code = 2'd2;
            end
            3'd6: begin
                enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
                if (imm12_bad) chk_code = 2'd1;
            end
            default: begin
                enc_word = {req_imm[31:12], req_rd, OP_LUI};
                if (req_imm[11:0] != 12'd0) chk_code = 2'd3;
            end
        endcase
    end

    // Next-state and register next values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = 2'd0;
        full_d     = full_q;
        clr_pend_d = clr_pend_q;
        unique case (state_q)
            IDLE: begin
                if (clr_eff) begin
                    addr_d     = ADDR_W'(BASE_ADDR);
                    count_d    = '0;
                    full_d     = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (req_valid) begin
                    if (chk_code != 2'd0) begin
                        err_d  = 1'b1;
                        code_d = chk_code;
                    end else begin
                        wdata_d = enc_word;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + CNT_W'(1);
                if (clear) clr_pend_d = 1'b1;
                if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
                    state_d = FULL;
                    full_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (clr_eff) begin
                    addr_d     = ADDR_W'(BASE_ADDR);
                    count_d    = '0;
                    full_d     = 1'b0;
                    clr_pend_d = 1'b0;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= ADDR_W'(BASE_ADDR);
            count_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
            full_q     <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            code_q     <= code_d;
            full_q     <= full_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed literal cases followed by random
// traffic, all checked against a transaction-level reference model.
module tb_instr_stream_encoder;

    localparam int AW    = 4;
    localparam int BASE  = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, clear, req_valid, req_ready;
    logic [2:0]  req_class, req_funct3;
    logic        req_funct7b5;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic [1:0]  err_code;
    logic        full;
    logic [2:0]  count;

    instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid),
        .req_ready(req_ready), .req_class(req_class), .req_funct3(req_funct3),
        .req_funct7b5(req_funct7b5), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .err(err), .err_code(err_code), .full(full),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference encoding built from shifts and masks on the raw immediate.
    function automatic logic [31:0] ref_enc(input int cls, input logic [31:0] f3,
            input logic [31:0] f7, input logic [31:0] rd, input logic [31:0] rs1,
            input logic [31:0] rs2, input logic [31:0] i);
        logic [31:0] w;
        case (cls)
            0: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            1: w = (i << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            2: w = (i << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            3: w = (((i >> 5) & 32'd127) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (32'd2 << 12) | ((i & 32'd31) << 7) | 32'h23;
            4: w = (((i >> 12) & 32'd1) << 31) | (((i >> 5) & 32'd63) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((i >> 1) & 32'd15) << 8)
                   | (((i >> 11) & 32'd1) << 7) | 32'h63;
            5: w = (((i >> 20) & 32'd1) << 31) | (((i >> 1) & 32'd1023) << 21)
                   | (((i >> 11) & 32'd1) << 20) | (((i >> 12) & 32'd255) << 12)
                   | (rd << 7) | 32'h6F;
            6: w = (i << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            default: w = (i & 32'hFFFFF000) | (rd << 7) | 32'h37;
        endcase
        return w;
    endfunction

    function automatic int ref_code(input int cls, input logic [31:0] imm);
        int s;
        s = int'($signed(imm));
        case (cls)
            1, 2, 3, 6: return (s < -2048 || s > 2047) ? 1 : 0;
            4: begin
                if (s < -4096 || s > 4094) return 1;
                return (s % 2 != 0) ? 2 : 0;
            end
            5: begin
                if (s < -1048576 || s > 1048574) return 1;
                return (s % 2 != 0) ? 2 : 0;
            end
            7: return ((imm & 32'hFFF) != 0) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    // Transaction-level model: a pending write, words stored, next address.
    bit          m_live = 0, m_took = 0, m_busy = 0, m_full = 0, m_pend = 0;
    int          m_cnt = 0, m_addr = BASE;
    bit          e_we = 0, e_err = 0;
    int          e_code = 0;
    logic [31:0] e_wdata = '0;

    always @(posedge clk) begin
        int c;
        m_took = 0;
        m_live = 1;
        e_we   = 0;
        e_err  = 0;
        e_code = 0;
        if (reset) begin
            m_busy = 0; m_full = 0; m_pend = 0; m_cnt = 0; m_addr = BASE; e_wdata = '0;
        end else if (m_busy) begin
            m_busy = 0;
            m_addr = (m_addr + 4) % (1 << AW);
            m_cnt++;
            if (clear) m_pend = 1;
            if (m_cnt == DEPTH) m_full = 1;
        end else if (clear || m_pend) begin
            m_addr = BASE; m_cnt = 0; m_full = 0; m_pend = 0;
        end else if (!m_full && req_valid) begin
            m_took = 1;
            c = ref_code(int'(req_class), req_imm);
            if (c != 0) begin
                e_err  = 1;
                e_code = c;
            end else begin
                e_wdata = ref_enc(int'(req_class), 32'(req_funct3), 32'(req_funct7b5),
                                  32'(req_rd), 32'(req_rs1), 32'(req_rs2), req_imm);
                m_busy = 1;
                e_we   = 1;
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("req_ready", 32'(req_ready),
                32'(!reset && !m_busy && !m_full && !clear && !m_pend));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("err", 32'(err), 32'(e_err));
            chk("err_code", 32'(err_code), 32'(e_code));
            chk("full", 32'(full), 32'(m_full));
            chk("count", 32'(count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int cls, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
        req_class    = 3'(cls);
        req_funct3   = 3'(f3);
        req_funct7b5 = 1'(f7);
        req_rd       = 5'(rd);
        req_rs1      = 5'(rs1);
        req_rs2      = 5'(rs2);
        req_imm      = imm;
    endtask

    task automatic send(input int cls, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input logic [31:0] imm);
        int k;
        drive(cls, f3, f7, rd, rs1, rs2, imm);
        req_valid = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!m_took && k < 20);
        req_valid = 1'b0;
        if (!m_took) begin
            n_total++;
            $display("FAIL send_timeout: request class %0d not accepted within 20 cycles", cls);
        end
    endtask

    function automatic logic [31:0] rand_imm();
        int b[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                      1048574, 1048575, 1048576, -1048576, -1048578, 6, 7};
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 8191)) - 4096);
            2: return 32'(b[$urandom_range(0, 15)]);
            3: return $urandom & 32'hFFFFF000;
            default: return 32'(int'($urandom_range(0, 4194303)) - 2097152);
        endcase
    endfunction

    initial begin
        int hold;
        reset = 1'b1; clear = 1'b0; req_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'd0);
        step(); step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd8);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd1);

        send(1, 0, 0, 1, 0, 0, 32'd5);
        chk("addi_wdata", mem_wdata, 32'h00500093);
        chk("addi_we", 32'(mem_we), 32'd1);
        chk("addi_addr", 32'(mem_addr), 32'd8);
        step();
        chk("addi_count", 32'(count), 32'd1);
        chk("addi_next_addr", 32'(mem_addr), 32'd12);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_count", 32'(count), 32'd0);

        send(0, 0, 0, 3, 1, 2, 32'd0);
        chk("add_wdata", mem_wdata, 32'h002081B3);
        chk("add_ready_low", 32'(req_ready), 32'd0);
        send(2, 0, 0, 5, 2, 0, 32'd8);
        chk("lw_wdata", mem_wdata, 32'h00812283);
        chk("lw_addr", 32'(mem_addr), 32'd12);
        send(3, 0, 0, 0, 2, 5, 32'd12);
        chk("sw_wdata", mem_wdata, 32'h00512623);
        chk("sw_addr_wrap", 32'(mem_addr), 32'd0);
        send(4, 0, 0, 0, 1, 2, 32'd8);
        chk("beq_wdata", mem_wdata, 32'h00208463);
        step();
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);

        drive(5, 0, 0, 1, 0, 0, 32'd16);
        req_valid = 1'b1;
        step(); step(); step();
        chk("held_no_we", 32'(mem_we), 32'd0);
        clear = 1'b1;
        #1;
        chk("clear_ready_low", 32'(req_ready), 32'd0);
        step();
        clear = 1'b0;
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_addr", 32'(mem_addr), 32'd8);
        step();
        req_valid = 1'b0;
        chk("jal_wdata", mem_wdata, 32'h010000EF);
        chk("jal_addr", 32'(mem_addr), 32'd8);

        send(7, 0, 0, 6, 0, 0, 32'h12345000);
        chk("lui_wdata", mem_wdata, 32'h12345337);
        send(1, 0, 0, 1, 0, 0, 32'd2048);
        chk("addi_range_err", 32'(err), 32'd1);
        chk("addi_range_code", 32'(err_code), 32'd1);
        chk("addi_range_no_we", 32'(mem_we), 32'd0);
        send(4, 0, 0, 0, 1, 2, 32'd6);
        chk("beq6_wdata", mem_wdata, 32'h00208363);
        send(4, 0, 0, 0, 1, 2, 32'd7);
        chk("beq7_code", 32'(err_code), 32'd2);
        send(7, 0, 0, 6, 0, 0, 32'h00001001);
        chk("lui_code", 32'(err_code), 32'd3);

        drive(1, 0, 0, 1, 0, 0, 32'd1);
        req_valid = 1'b1; clear = 1'b1;
        #1;
        chk("clr_vs_valid_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 1'b0; clear = 1'b0;
        chk("clr_vs_valid_no_we", 32'(mem_we), 32'd0);

        req_valid = 1'b1; reset = 1'b1;
        step();
        req_valid = 1'b0; reset = 1'b0;
        chk("rst_req_no_we", 32'(mem_we), 32'd0);
        send(1, 0, 0, 1, 0, 0, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_write_count", 32'(count), 32'd0);
        chk("rst_write_addr", 32'(mem_addr), 32'd8);

        // Random traffic; a held request keeps its fields until taken.
        hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!req_valid) begin
                drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm());
                req_valid = ($urandom_range(0, 2) != 0);
                hold = 0;
            end
            clear = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
            hold++;
            if (m_took || hold > 60) req_valid = 1'b0;
        end
        clear = 1'b0; reset = 1'b0; req_valid = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
